sram_arb: RTL and testbench
===========================

Name: sram_arb

Overview:
- Round-robin arbiter that shares one single-port synchronous SRAM between N requesters, e.g. instruction fetch, load/store and debug/DMA.
- Drives the SRAM through a sram_if master modport and has one-cycle read latency.
- Routes each read response back to the requester that issued it.
- Writes are posted: they complete on grant and produce no response.

Parameters:
- N, 2: number of requesters (2..8).
- AW, 15: word address width; must match the SRAM.
- DW, 32: data width; must match the SRAM.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  N  request valid, one bit per requester.
- req_rdy  out  N  request accepted this cycle (grant).
- req_wen  in  N  1 = write, 0 = read.
- req_addr  in  N*AW  packed word addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  N*DW  packed write data.
- rsp_vld  out  N  read data valid for requester i. No backpressure; the requester must accept it.
- rsp_rdata  out  DW  read data, shared by all requesters.
- sram_rw  sram_if.master  -  addr, wen, wdata to the SRAM; rdata from the SRAM.

Behaviour:
- Arbitration is combinational within cycle T.
  - Requester i is granted if req_vld[i] is set and it is the first valid requester at or after ptr_q, scanning upward with wrap.
  - req_rdy has exactly one bit set when any req_vld is set, and is all zeros otherwise.
  - A request transfers when req_vld[i] & req_rdy[i].
- SRAM drive:
  - sram_rw.addr and sram_rw.wdata take the granted requester's fields.
  - sram_rw.wen = granted & req_wen[g].
  - When idle, wen=0 and addr holds its last value. The resulting dummy read is harmless because no response is generated for it.
- ptr_q, log2(N) bits, reset value 0.
  - On a grant to g, ptr_q <= (g+1) mod N, wrapping from N-1 to 0.
  - With no grant, ptr_q is unchanged.
- Read tracking: rd_pend_q (1 bit) and rd_id_q (log2(N) bits).
  - Set on a read grant and loaded with g.
  - Cleared when the following cycle has no read grant.
- Response timing: a read granted in cycle T gives rsp_vld[rd_id_q]=1 in T+1, with rsp_rdata = sram_rw.rdata.
  - Back-to-back reads are fully pipelined: one grant and one response per cycle.
- Writes: no rsp_vld.
  - A write at T followed by a read of the same address at T+1 returns the new data.
- Outputs under reset:
  - rsp_vld=0, ptr_q=0, rd_pend_q=0, rd_id_q=0.
  - req_rdy depends only on req_vld and ptr_q.
  - rsp_rdata is the SRAM output and is undefined until the first read.
- Reset asserted mid-read drops the in-flight response; no rsp_vld after reset release.
- Requesters may change or drop req_vld in any cycle that did not transfer. The arbiter holds no request state.
- Simultaneous requests from all N requesters are each granted once per N cycles (starvation-free).

Optional Feature:
- SRAM_ARB_RSP_REG_EN. When defined, an extra response pipeline stage is added: rdata and the response valid/id are registered.
  - Read latency becomes 2: grant at T gives rsp_vld at T+2.
  - Throughput is unchanged.
  - rsp_rdata is registered and resets to 0.
- When undefined: latency 1 as above, and rsp_rdata is combinational from the SRAM.

Decomposition:
- Package sram_arb_pkg holds:
  - the localparam for maximum N;
  - the function clog2_min1(n), returning at least 1;
  - typedef arb_id_t for the requester index.
- Sub-module rr_arb(N): inputs req (N) and ptr; outputs one-hot gnt and binary gnt_id. It is purely combinational and reused by other arbiters in the design.
- Everything else (pointer update, read tracking, response pipe, SRAM muxing) lives in sram_arb.

Test Plan:
- Single read, 1 cycle latency: pre-load mem[0x10]=0xDEADBEEF; req0 read 0x10 at T → req_rdy=2'b01 at T; rsp_vld=2'b01 and rsp_rdata=0xDEADBEEF at T+1.
- Round-robin fairness: N=2, both requesters read continuously for 6 cycles after reset → grants 0,1,0,1,0,1; each rsp_vld goes to the matching id at +1.
- Write then read: req1 writes 0x5A5A0001 to 0x7FFF (top address) at T; req0 reads 0x7FFF at T+1 → rsp_vld=2'b01 at T+2 with data 0x5A5A0001; no rsp_vld at T+1.
- Pointer wrap: N=4, only req3 then req0 valid → grant 3 sets ptr=0; req0 is granted next cycle; ptr=1.
- Reset mid-read: req0 read granted at T; rst_n low at T+0.5, released at T+2 → rsp_vld stays 0 and ptr=0.
- SRAM_ARB_RSP_REG_EN: repeat scenario 1 → rsp_vld at T+2; back-to-back reads from cycle 0 to 0x0..0x3 produce 4 consecutive responses starting at cycle 2.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter and its round-robin core.
package sram_arb_pkg;

    localparam int MAX_N = 8;

    // Index width for n requesters; never zero, so a 1-bit index survives n=2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [clog2_min1(MAX_N)-1:0] arb_id_t;

endpackage

// File: rtl/sram_if.sv
// Single-port synchronous SRAM port bundle: one access per cycle, read data one cycle later.
interface sram_if #(
    parameter int AW = 15,
    parameter int DW = 32
);
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output addr, output wen, output wdata, input rdata);
    modport slave  (input addr, input wen, input wdata, output rdata);
endinterface

// File: rtl/sram_arb_rr_arb.sv
// rr_arb: combinational round-robin picker; the first set req at or after ptr wins, with wrap.
module rr_arb
    import sram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]               req,
    input  logic [clog2_min1(N)-1:0]   ptr,
    output logic [N-1:0]               gnt,
    output logic [clog2_min1(N)-1:0]   gnt_id
);
    localparam int IDW = clog2_min1(N);

    logic found;
    int   idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/sram_arb.sv
// sram_arb: round-robin sharing of one single-port SRAM among N requesters, reads routed back by id.
// Define SRAM_ARB_RSP_REG_EN to register the read response (latency 2 instead of 1).
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 15,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_vld,
    output logic [N-1:0]    req_rdy,
    input  logic [N-1:0]    req_wen,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    output logic [N-1:0]    rsp_vld,
    output logic [DW-1:0]   rsp_rdata,
    sram_if.master          sram_rw
);
    localparam int IDW = clog2_min1(N);

    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("sram_arb: N=%0d outside 2..%0d", N, MAX_N);
    end

    logic [IDW-1:0] ptr_q;
    logic           rd_pend_q;
    logic [IDW-1:0] rd_id_q;

    logic [N-1:0]   gnt_p0;
    logic [IDW-1:0] gnt_id_p0;
    logic           gnt_any_p0;
    logic           rd_gnt_p0;
    logic [AW-1:0]  addr_p0;
    logic [AW-1:0]  addr_hold_q;

    // Stage p0: arbitrate and drive the SRAM in the grant cycle.
    rr_arb #(.N(N)) u_rr_arb (
        .req    (req_vld),
        .ptr    (ptr_q),
        .gnt    (gnt_p0),
        .gnt_id (gnt_id_p0)
    );

    assign gnt_any_p0 = |gnt_p0;
    assign rd_gnt_p0  = gnt_any_p0 & ~req_wen[gnt_id_p0];
    assign req_rdy    = gnt_p0;

    // Idle cycles repeat the last address; the resulting dummy read has no response.
    assign addr_p0       = gnt_any_p0 ? req_addr[int'(gnt_id_p0)*AW +: AW] : addr_hold_q;
    assign sram_rw.addr  = addr_p0;
    assign sram_rw.wen   = gnt_any_p0 & req_wen[gnt_id_p0];
    assign sram_rw.wdata = req_wdata[int'(gnt_id_p0)*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            if (gnt_any_p0) begin
                ptr_q <= (int'(gnt_id_p0) == N - 1) ? '0 : gnt_id_p0 + 1'b1;
            end
            rd_pend_q <= rd_gnt_p0;
            if (rd_gnt_p0) begin
                rd_id_q <= gnt_id_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_any_p0) begin
            addr_hold_q <= addr_p0;
        end
    end

    // Stage p1: SRAM data returns; steer the valid to the requester that issued the read.
    logic [N-1:0] rsp_vld_p1;

    always_comb begin
        rsp_vld_p1 = '0;
        if (rd_pend_q) begin
            rsp_vld_p1[rd_id_q] = 1'b1;
        end
    end

`ifdef SRAM_ARB_RSP_REG_EN
    // Stage p2: registered response for timing-critical requesters.
    logic [N-1:0]  vld_p2;
    logic [DW-1:0] rdata_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= '0;
            rdata_p2 <= '0;
        end else begin
            vld_p2 <= rsp_vld_p1;
            if (rd_pend_q) begin
                rdata_p2 <= sram_rw.rdata;
            end
        end
    end

    assign rsp_vld   = vld_p2;
    assign rsp_rdata = rdata_p2;
`else
    assign rsp_vld   = rsp_vld_p1;
    assign rsp_rdata = sram_rw.rdata;
`endif

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: an N=2 instance for the read/write/latency scenarios, an N=4 instance for pointer wrap.
`timescale 1ns/1ps
module tb_sram_arb;
    localparam int AW = 15;
    localparam int DW = 32;
`ifdef SRAM_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]      req_vld, req_rdy, req_wen, rsp_vld;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata;

    logic [3:0]      vld4, rdy4, wen4, rsp_vld4;
    logic [4*AW-1:0] addr4;
    logic [4*DW-1:0] wdata4;
    logic [DW-1:0]   rsp_rdata4;

    sram_if #(.AW(AW), .DW(DW)) sif2 ();
    sram_if #(.AW(AW), .DW(DW)) sif4 ();

    sram_arb #(.N(2), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_vld   (rsp_vld),
        .rsp_rdata (rsp_rdata),
        .sram_rw   (sif2)
    );

    sram_arb #(.N(4), .AW(AW), .DW(DW)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld   (vld4),
        .req_rdy   (rdy4),
        .req_wen   (wen4),
        .req_addr  (addr4),
        .req_wdata (wdata4),
        .rsp_vld   (rsp_vld4),
        .rsp_rdata (rsp_rdata4),
        .sram_rw   (sif4)
    );

    // Preloaded SRAM contents for never-written words.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 15'h0010) return 32'hDEADBEEF;
        return {17'h0CAFE, a};
    endfunction

    logic                 mem_init_done = 1'b0;
    logic [DW-1:0]        mem [0:(1<<AW)-1];
    logic [(1<<AW)-1:0]   written;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            written <= '0;
        end else if (sif2.wen) begin
            mem[sif2.addr]     <= sif2.wdata;
            written[sif2.addr] <= 1'b1;
        end
        sif2.rdata <= written[sif2.addr] ? mem[sif2.addr] : init_val(sif2.addr);
    end

    always @(posedge clk) begin
        sif4.rdata <= init_val(sif4.addr);
    end

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sbq[$];

    task automatic drive2(input logic [1:0] v, input logic [1:0] w,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        req_vld   = v;
        req_wen   = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive2(2'b00, 2'b00, '0, '0, '0, '0);
        vld4 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic [DW-1:0] data);
        exp_t e;
        e.due  = cyc + LAT;
        e.id   = id;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive2(2'b00, 2'b00, '0, '0, '0, '0);
        vld4 = '0; wen4 = '0; addr4 = '0; wdata4 = '0;
        @(negedge clk);
        n_cmp++;
        if (rsp_vld !== 2'b00) begin
            n_fail++; $display("FAIL reset_rsp_vld got=%b want=00", rsp_vld);
        end
        n_cmp++;
        if (req_rdy !== 2'b00) begin
            n_fail++; $display("FAIL reset_rdy_idle got=%b want=00", req_rdy);
        end
        req_vld = 2'b11;
        vld4    = 4'b0110;
        #1;
        n_cmp++;
        if (req_rdy !== 2'b01) begin
            n_fail++; $display("FAIL reset_rdy_ptr0 got=%b want=01", req_rdy);
        end
        n_cmp++;
        if (rdy4 !== 4'b0010) begin
            n_fail++; $display("FAIL reset_rdy4_ptr0 got=%b want=0010", rdy4);
        end
`ifdef SRAM_ARB_RSP_REG_EN
        n_cmp++;
        if (rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got=%h want=00000000", rsp_rdata);
        end
`endif
        @(posedge clk);
        #1;
        mem_init_done = 1'b1;
        drive2(2'b00, 2'b00, '0, '0, '0, '0);
        vld4  = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_ptr_wrap();
        logic [3:0] vt [6] = '{4'b1000, 4'b0001, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        logic [3:0] et [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 6; k++) begin
            vld4   = vt[k];
            wen4   = 4'b1111;
            addr4  = {15'h0103, 15'h0102, 15'h0101, 15'h0100};
            wdata4 = {4{32'h1234_0000 + 32'(k)}};
            @(negedge clk);
            n_cmp++;
            if (rdy4 !== et[k]) begin
                n_fail++; $display("FAIL ptr_wrap_rdy k=%0d got=%b want=%b", k, rdy4, et[k]);
            end
            n_cmp++;
            if (rsp_vld4 !== 4'b0000) begin
                n_fail++; $display("FAIL ptr_wrap_no_rsp k=%0d got=%b want=0000", k, rsp_vld4);
            end
            next_cycle();
        end
        vld4 = '0;
    endtask

    task automatic test_single_read();
        exp_t       e;
        logic [1:0] exp_rdy;
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k == 0) drive2(2'b01, 2'b00, 15'h0010, '0, '0, '0);
            else        drive2(2'b00, 2'b00, '0, '0, '0, '0);
            exp_rdy = (k == 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            n_cmp++;
            if (req_rdy !== exp_rdy) begin
                n_fail++; $display("FAIL single_read_rdy k=%0d got=%b want=%b", k, req_rdy, exp_rdy);
            end
            if (k == 0) push_exp(0, 32'hDEADBEEF);
            n_cmp++;
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                if (rsp_vld !== 2'(1 << e.id) || rsp_rdata !== e.data) begin
                    n_fail++; $display("FAIL single_read_rsp k=%0d got vld=%b data=%h want vld=%b data=%h",
                                       k, rsp_vld, rsp_rdata, 2'(1 << e.id), e.data);
                end
            end else if (rsp_vld !== 2'b00) begin
                n_fail++; $display("FAIL single_read_idle k=%0d got vld=%b want=00", k, rsp_vld);
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        exp_t          e;
        logic [1:0]    exp_rdy;
        logic [AW-1:0] a0, a1;
        do_reset();
        for (int k = 0; k < 6 + LAT + 1; k++) begin
            a0 = AW'(32'h0100 + k);
            a1 = AW'(32'h0200 + k);
            if (k < 6) drive2(2'b11, 2'b00, a0, a1, '0, '0);
            else       drive2(2'b00, 2'b00, '0, '0, '0, '0);
            exp_rdy = (k >= 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
            n_cmp++;
            if (req_rdy !== exp_rdy) begin
                n_fail++; $display("FAIL round_robin_rdy k=%0d got=%b want=%b", k, req_rdy, exp_rdy);
            end
            if (k < 6) push_exp(k % 2, init_val((k % 2 == 0) ? a0 : a1));
            n_cmp++;
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                if (rsp_vld !== 2'(1 << e.id) || rsp_rdata !== e.data) begin
                    n_fail++; $display("FAIL round_robin_rsp k=%0d got vld=%b data=%h want vld=%b data=%h",
                                       k, rsp_vld, rsp_rdata, 2'(1 << e.id), e.data);
                end
            end else if (rsp_vld !== 2'b00) begin
                n_fail++; $display("FAIL round_robin_idle k=%0d got vld=%b want=00", k, rsp_vld);
            end
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        exp_t       e;
        logic [1:0] exp_rdy;
        for (int k = 0; k < 2 + LAT + 1; k++) begin
            if (k == 0)      drive2(2'b10, 2'b10, '0, 15'h7FFF, '0, 32'h5A5A0001);
            else if (k == 1) drive2(2'b01, 2'b00, 15'h7FFF, '0, '0, '0);
            else             drive2(2'b00, 2'b00, '0, '0, '0, '0);
            exp_rdy = (k == 0) ? 2'b10 : ((k == 1) ? 2'b01 : 2'b00);
            @(negedge clk);
            n_cmp++;
            if (req_rdy !== exp_rdy) begin
                n_fail++; $display("FAIL write_read_rdy k=%0d got=%b want=%b", k, req_rdy, exp_rdy);
            end
            if (k == 1) push_exp(0, 32'h5A5A0001);
            n_cmp++;
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                if (rsp_vld !== 2'(1 << e.id) || rsp_rdata !== e.data) begin
                    n_fail++; $display("FAIL write_read_rsp k=%0d got vld=%b data=%h want vld=%b data=%h",
                                       k, rsp_vld, rsp_rdata, 2'(1 << e.id), e.data);
                end
            end else if (rsp_vld !== 2'b00) begin
                n_fail++; $display("FAIL write_read_idle k=%0d got vld=%b want=00", k, rsp_vld);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [1:0] exp_rdy;
        do_reset();
        for (int k = 0; k < 4 + LAT + 1; k++) begin
            if (k < 4) drive2(2'b01, 2'b00, AW'(k), '0, '0, '0);
            else       drive2(2'b00, 2'b00, '0, '0, '0, '0);
            exp_rdy = (k < 4) ? 2'b01 : 2'b00;
            @(negedge clk);
            n_cmp++;
            if (req_rdy !== exp_rdy) begin
                n_fail++; $display("FAIL back_to_back_rdy k=%0d got=%b want=%b", k, req_rdy, exp_rdy);
            end
            if (k < 4) push_exp(0, init_val(AW'(k)));
            n_cmp++;
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                if (rsp_vld !== 2'(1 << e.id) || rsp_rdata !== e.data) begin
                    n_fail++; $display("FAIL back_to_back_rsp k=%0d got vld=%b data=%h want vld=%b data=%h",
                                       k, rsp_vld, rsp_rdata, 2'(1 << e.id), e.data);
                end
            end else if (rsp_vld !== 2'b00) begin
                n_fail++; $display("FAIL back_to_back_idle k=%0d got vld=%b want=00", k, rsp_vld);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_read();
        exp_t       e;
        logic [1:0] exp_rdy;
        drive2(2'b10, 2'b00, '0, 15'h0020, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (req_rdy !== 2'b10) begin
            n_fail++; $display("FAIL reset_mid_grant got=%b want=10", req_rdy);
        end
        rst_n = 1'b0;
        drive2(2'b00, 2'b00, '0, '0, '0, '0);
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (rsp_vld !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid_in_reset got=%b want=00", rsp_vld);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k == 0) drive2(2'b11, 2'b00, 15'h0030, 15'h0031, '0, '0);
            else        drive2(2'b00, 2'b00, '0, '0, '0, '0);
            exp_rdy = (k == 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            n_cmp++;
            if (req_rdy !== exp_rdy) begin
                n_fail++; $display("FAIL reset_mid_ptr k=%0d got=%b want=%b", k, req_rdy, exp_rdy);
            end
            if (k == 0) push_exp(0, init_val(15'h0030));
            n_cmp++;
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                if (rsp_vld !== 2'(1 << e.id) || rsp_rdata !== e.data) begin
                    n_fail++; $display("FAIL reset_mid_rsp k=%0d got vld=%b data=%h want vld=%b data=%h",
                                       k, rsp_vld, rsp_rdata, 2'(1 << e.id), e.data);
                end
            end else if (rsp_vld !== 2'b00) begin
                n_fail++; $display("FAIL reset_mid_stale k=%0d got vld=%b want=00", k, rsp_vld);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_ptr_wrap();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
